// File: rtl/barrel_shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Mode encoding plus a width-generic bit reversal.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SHL      = 2'd0,
    MODE_SHR      = 2'd1,
    MODE_ROL      = 2'd2,
    MODE_FLIP_SHL = 2'd3
  } mode_e;

  localparam int BSP_MAX_W = 64;

  // Reverses the low w bits of d; callers cast the result to w bits.
  function automatic logic [BSP_MAX_W-1:0] bit_reverse(
    input logic [BSP_MAX_W-1:0] d,
    input int                   w
  );
    logic [BSP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BSP_MAX_W; i++) begin
      if (i < w) r[w-1-i] = d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Valid/ready bus of the barrel shifter: request side and result side.
// master = producer/consumer environment, slave = the shifter.
interface barrel_shift_pipe_if #(
  parameter int WIDTH      = 16,
  parameter int WIDTH_LOG2 = 4,
  parameter int TAG_W      = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [WIDTH_LOG2-1:0] in_amt;
  logic [1:0]            in_mode;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, in_data, in_amt,
    output in_mode, in_tag, out_ready,
    input  in_ready, out_valid,
    input  out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt,
    input  in_mode, in_tag, out_ready,
    output in_ready, out_valid,
    output out_data, out_tag
  );
endinterface

// File: rtl/barrel_shift_stage.sv
// One pipeline stage: conditional 2^STAGE shift/rotate selected by
// amt bit STAGE, followed by a holdable register of the whole bundle.
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int WIDTH_LOG2 = 4,
  parameter int TAG_W      = 4,
  parameter int STAGE      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic [WIDTH_LOG2-1:0] amt_i,
  input  mode_e                 mode_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [WIDTH_LOG2-1:0] amt_o,
  output mode_e                 mode_o,
  output logic [TAG_W-1:0]      tag_o
);

  localparam int SH = 1 << STAGE;

  logic                  valid_q;
  logic [WIDTH-1:0]      data_d;
  logic [WIDTH-1:0]      data_q;
  logic [WIDTH_LOG2-1:0] amt_q;
  mode_e                 mode_q;
  logic [TAG_W-1:0]      tag_q;

  always_comb begin
    data_d = data_i;
    if (amt_i[STAGE]) begin
      unique case (mode_i)
        MODE_SHR: data_d = data_i >> SH;
        MODE_ROL: data_d = (data_i << SH)
                         | (data_i >> (WIDTH - SH));
        MODE_SHL,
        MODE_FLIP_SHL: data_d = data_i << SH;
        default: data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= MODE_SHL;
      tag_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      mode_q  <= mode_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (SHL/SHR/ROL/FLIP_SHL), WIDTH_LOG2 stages,
// global stall; BARREL_SHIFT_PIPE_STATS_EN adds xfer/stall counters.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int WIDTH_LOG2 = 4,
  parameter int TAG_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  barrel_shift_pipe_if.slave  bus_if
`ifdef BARREL_SHIFT_PIPE_STATS_EN
  ,
  output logic [31:0]         stat_xfers_o,
  output logic [31:0]         stat_stalls_o
`endif
);

  logic                  stall;
  logic                  v_s    [0:WIDTH_LOG2];
  logic [WIDTH-1:0]      d_s    [0:WIDTH_LOG2];
  logic [WIDTH_LOG2-1:0] amt_s  [0:WIDTH_LOG2];
  mode_e                 mode_s [0:WIDTH_LOG2];
  logic [TAG_W-1:0]      tag_s  [0:WIDTH_LOG2];
  logic [BSP_MAX_W-1:0]  in_ext;
  logic                  unused_tail;

  assign stall = bus_if.out_valid & ~bus_if.out_ready;
  assign bus_if.in_ready = ~stall;

  // Reversal happens before stage 0, so FLIP_SHL is plain SHL after it.
  assign in_ext    = BSP_MAX_W'(bus_if.in_data);
  assign mode_s[0] = mode_e'(bus_if.in_mode);
  assign v_s[0]    = bus_if.in_valid;
  assign amt_s[0]  = bus_if.in_amt;
  assign tag_s[0]  = bus_if.in_tag;
  assign d_s[0]    = (mode_s[0] == MODE_FLIP_SHL)
                   ? WIDTH'(bit_reverse(in_ext, WIDTH))
                   : bus_if.in_data;

  for (genvar k = 0; k < WIDTH_LOG2; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH      (WIDTH),
      .WIDTH_LOG2 (WIDTH_LOG2),
      .TAG_W      (TAG_W),
      .STAGE      (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (~stall),
      .valid_i (v_s[k]),
      .data_i  (d_s[k]),
      .amt_i   (amt_s[k]),
      .mode_i  (mode_s[k]),
      .tag_i   (tag_s[k]),
      .valid_o (v_s[k+1]),
      .data_o  (d_s[k+1]),
      .amt_o   (amt_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .tag_o   (tag_s[k+1])
    );
  end

  assign bus_if.out_valid = v_s[WIDTH_LOG2];
  assign bus_if.out_data  = d_s[WIDTH_LOG2];
  assign bus_if.out_tag   = tag_s[WIDTH_LOG2];
  assign unused_tail = ^{amt_s[WIDTH_LOG2], mode_s[WIDTH_LOG2]};

`ifdef BARREL_SHIFT_PIPE_STATS_EN
  logic [31:0] xfers_q;
  logic [31:0] xfers_d;
  logic [31:0] stalls_q;
  logic [31:0] stalls_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    xfers_d  = xfers_q;
    stalls_d = stalls_q;
    if (bus_if.out_valid && bus_if.out_ready && xfers_q != '1)
      xfers_d = xfers_q + 32'd1;
    if (stall && stalls_q != '1)
      stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else begin
      xfers_q  <= xfers_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_xfers_o  = xfers_q;
  assign stat_stalls_o = stalls_q;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and random checks for barrel_shift_pipe at WIDTH=16.
// Stats checks are compiled in with BARREL_SHIFT_PIPE_STATS_EN.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  barrel_shift_pipe_if #(.WIDTH(16), .WIDTH_LOG2(4), .TAG_W(4)) bus ();

`ifdef BARREL_SHIFT_PIPE_STATS_EN
  logic [31:0] stat_xfers;
  logic [31:0] stat_stalls;
`endif

  barrel_shift_pipe #(.WIDTH(16), .WIDTH_LOG2(4), .TAG_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
`ifdef BARREL_SHIFT_PIPE_STATS_EN
    ,
    .stat_xfers_o  (stat_xfers),
    .stat_stalls_o (stat_stalls)
`endif
  );

  // Bit-by-bit reference, written independently of the staged datapath.
  function automatic logic [15:0] ref_shift(
    input logic [15:0] d, input logic [3:0] a, input logic [1:0] m
  );
    logic [15:0] r;
    logic [15:0] src;
    r = '0;
    src = d;
    if (m == 2'd3) for (int i = 0; i < 16; i++) src[15-i] = d[i];
    for (int i = 0; i < 16; i++) begin
      case (m)
        2'd1: if (i + int'(a) < 16) r[i] = src[i+int'(a)];
        2'd2: r[(i+int'(a))%16] = src[i];
        default: if (i + int'(a) < 16) r[i+int'(a)] = src[i];
      endcase
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_amt   = '0;
    bus.in_mode  = '0;
    bus.in_tag   = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0000", bus.out_data);
    end
    checks++;
    if (bus.out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_tag: got %h expected 0", bus.out_tag);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_shl_latency();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0005;
    bus.in_amt   = 4'd3;
    bus.in_mode  = 2'd0;
    bus.in_tag   = 4'hA;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early: got %b expected 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_valid: got %b expected 1", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 16'h0028) begin
      errors++;
      $display("FAIL lat_data: got %h expected 0028", bus.out_data);
    end
    checks++;
    if (bus.out_tag !== 4'hA) begin
      errors++;
      $display("FAIL lat_tag: got %h expected a", bus.out_tag);
    end
    @(posedge clk);
  endtask

  task automatic test_modes();
    logic [15:0] vd [7] = '{16'h0005, 16'h0005, 16'h8001, 16'h8000,
                            16'hFFFF, 16'h1234, 16'hABCD};
    logic [3:0]  va [7] = '{4'd0, 4'd1, 4'd1, 4'd15, 4'd15, 4'd4, 4'd4};
    logic [1:0]  vm [7] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [15:0] ve [7] = '{16'hA000, 16'h4000, 16'h0003, 16'h0001,
                            16'h8000, 16'h2341, 16'h0ABC};
    bit seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vd[i];
      bus.in_amt   = va[i];
      bus.in_mode  = vm[i];
      bus.in_tag   = 4'(i + 3);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clk);
        #1;
        seen = bus.out_valid;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL mode%0d_timeout: got no result expected one", i);
      end else begin
        checks++;
        if (bus.out_data !== ve[i]) begin
          errors++;
          $display("FAIL mode%0d_data: got %h expected %h",
                   i, bus.out_data, ve[i]);
        end
        checks++;
        if (bus.out_tag !== 4'(i + 3)) begin
          errors++;
          $display("FAIL mode%0d_tag: got %h expected %h",
                   i, bus.out_tag, 4'(i + 3));
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vd [8] = '{16'h0001, 16'h00F0, 16'h8001, 16'hC003,
                            16'h1234, 16'h0F0F, 16'hFFFF, 16'h0005};
    logic [3:0]  va [8] = '{4'd1, 4'd4, 4'd3, 4'd8, 4'd0, 4'd7, 4'd2, 4'd5};
    logic [1:0]  vm [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [15:0] qd [$];
    logic [3:0]  qt [$];
    logic [15:0] held;
    logic [15:0] ed;
    logic [3:0]  et;
    bit stall_prev;
    bit acc;
    bit dlv;
    int sent;
    int got;
    apply_reset();
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = vd[sent];
        bus.in_amt   = va[sent];
        bus.in_mode  = vm[sent];
        bus.in_tag   = 4'(sent);
      end else begin
        idle_inputs();
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready: got %b expected 0", bus.in_ready);
        end
        if (stall_prev) begin
          checks++;
          if (bus.out_data !== held) begin
            errors++;
            $display("FAIL b2b_stable: got %h expected %h",
                     bus.out_data, held);
          end
        end
        held = bus.out_data;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      dlv = bus.out_valid && bus.out_ready;
      if (dlv) begin
        ed = (qd.size() > 0) ? qd.pop_front() : 16'hxxxx;
        et = (qt.size() > 0) ? qt.pop_front() : 4'hx;
        checks++;
        if (bus.out_data !== ed || bus.out_tag !== et) begin
          errors++;
          $display("FAIL b2b_out%0d: got %h/%h expected %h/%h",
                   got, bus.out_data, bus.out_tag, ed, et);
        end
        got++;
      end
      if (acc) begin
        qd.push_back(ref_shift(vd[sent], va[sent], vm[sent]));
        qt.push_back(4'(sent));
        sent++;
      end
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 8", got);
    end
    @(negedge clk);
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid %b expected 0", bus.out_valid);
    end
`ifdef BARREL_SHIFT_PIPE_STATS_EN
    checks++;
    if (stat_xfers !== 32'd8) begin
      errors++;
      $display("FAIL stat_xfers: got %0d expected 8", stat_xfers);
    end
    checks++;
    if (stat_stalls !== 32'd5) begin
      errors++;
      $display("FAIL stat_stalls: got %0d expected 5", stat_stalls);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    bit seen;
    int n;
    apply_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0100 + 16'(i);
      bus.in_amt   = 4'd2;
      bus.in_mode  = 2'd0;
      bus.in_tag   = 4'(i + 1);
    end
    @(negedge clk);
    idle_inputs();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = bus.out_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_fill: got no valid expected valid");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async: got %b/%h expected 0/0000",
               bus.out_valid, bus.out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    bus.in_amt   = 4'd4;
    bus.in_mode  = 2'd0;
    bus.in_tag   = 4'h9;
    @(negedge clk);
    idle_inputs();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        n++;
        checks++;
        if (bus.out_data !== 16'h0010 || bus.out_tag !== 4'h9) begin
          errors++;
          $display("FAIL mid_new: got %h/%h expected 0010/9",
                   bus.out_data, bus.out_tag);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL mid_count: got %0d expected 1", n);
    end
  endtask

  task automatic test_random();
    logic [15:0] qd [$];
    logic [3:0]  qt [$];
    logic [15:0] ed;
    logic [3:0]  et;
    logic [15:0] rd;
    logic [3:0]  ra;
    logic [1:0]  rm;
    int sent;
    int got;
    apply_reset();
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (!bus.in_valid || bus.in_ready) begin
        if (sent < 40 && $urandom_range(0, 9) < 7) begin
          rd = 16'($urandom);
          ra = 4'($urandom);
          rm = 2'($urandom);
          bus.in_valid = 1'b1;
          bus.in_data  = rd;
          bus.in_amt   = ra;
          bus.in_mode  = rm;
          bus.in_tag   = 4'(sent);
        end else begin
          idle_inputs();
        end
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        ed = (qd.size() > 0) ? qd.pop_front() : 16'hxxxx;
        et = (qt.size() > 0) ? qt.pop_front() : 4'hx;
        checks++;
        if (bus.out_data !== ed || bus.out_tag !== et) begin
          errors++;
          $display("FAIL rand_out%0d: got %h/%h expected %h/%h",
                   got, bus.out_data, bus.out_tag, ed, et);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        qd.push_back(ref_shift(bus.in_data, bus.in_amt, bus.in_mode));
        qt.push_back(bus.in_tag);
        sent++;
      end
    end
    checks++;
    if (got != 40) begin
      errors++;
      $display("FAIL rand_count: got %0d expected 40", got);
    end
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b1;
    test_reset();
    test_shl_latency();
    test_modes();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
